// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a shared FIFO. Tracks per-requester outstanding
// entries against a quota and supports drain and flush.
module fifo_push_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QUOTA      = 4,
  parameter int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned CW         = $clog2(QUOTA + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_push_o,
  output logic [IDW+DATA_WIDTH-1:0]     fifo_data_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_pop_i,
  input  logic [IDW-1:0]                fifo_pop_id_i,
  input  logic                          drain_i,
  output logic                          drain_done_o,
  output logic                          busy_o,
  output logic [NUM_REQ*CW-1:0]         occupancy_o,
  output logic                          err_o
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [CW-1:0]         cnt_q [NUM_REQ];
  logic [CW-1:0]         cnt_d [NUM_REQ];
  logic [IDW-1:0]        rr_q, rr_d;
  logic [1:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    inc, dec;
  logic                  run_ok;
  logic                  gnt_found;
  logic [IDW-1:0]        winner;
  logic                  pop_err;
  logic                  all_zero_d;
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
    return IDW'(v % NUM_REQ);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_data[g]                 = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign occupancy_o[g*CW +: CW]     = cnt_q[g];
  end

  // Reset also masks grants so nothing is admitted in the reset cycle.
  assign run_ok = (state_q == StRun) & ~drain_i & ~fifo_full_i & ~flush_i & ~rst_i;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] & (cnt_q[i] < CW'(QUOTA)) & run_ok;
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    winner    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && elig[wrap_idx(32'(rr_q) + k)]) begin
        gnt_found = 1'b1;
        winner    = wrap_idx(32'(rr_q) + k);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    fifo_data_o = '0;
    if (gnt_found) begin
      req_ready_o[winner] = 1'b1;
      fifo_data_o         = {winner, req_data[winner]};
    end
  end

  assign fifo_push_o = gnt_found;

  // A pop is honoured only against a matching id with a non-zero count; otherwise it is an error.
  always_comb begin
    pop_err    = fifo_pop_i;
    all_zero_d = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc[i]   = gnt_found && (winner == IDW'(i));
      dec[i]   = fifo_pop_i && (fifo_pop_id_i == IDW'(i)) && (cnt_q[i] != '0);
      if (dec[i]) pop_err = 1'b0;
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (flush_i) cnt_d[i] = '0;
      if (cnt_d[i] != '0) all_zero_d = 1'b0;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (flush_i) begin
      rr_d = '0;
    end else if (gnt_found) begin
      rr_d = wrap_idx(32'(winner) + 32'd1);
    end
  end

  assign err_d = flush_i ? err_q : (err_q | pop_err);

  // Abandoning the drain takes priority over completing it in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!flush_i) begin
      case (state_q)
        StRun:   if (drain_i) state_d = StDrain;
        StDrain: begin
          if (!drain_i) begin
            state_d = StRun;
          end else if (all_zero_d) begin
            state_d = StDone;
          end
        end
        StDone:  if (!drain_i) state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      rr_q    <= '0;
      state_q <= StRun;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      rr_q    <= rr_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cnt_q[i] != '0) busy_o = 1'b1;
    end
  end

  assign drain_done_o = (state_q == StDone);
  assign err_o        = err_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: driver computes expectations from a queue-free
// behavioural model, a separate monitor compares DUT outputs against them.
module tb_fifo_push_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int QUOTA = 4;
  localparam int IDW   = 2;
  localparam int CW    = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N*DW-1:0]   req_data_i = '0;
  logic [N-1:0]      req_ready_o;
  logic              fifo_push_o;
  logic [IDW+DW-1:0] fifo_data_o;
  logic              fifo_full_i = 1'b0;
  logic              fifo_pop_i = 1'b0;
  logic [IDW-1:0]    fifo_pop_id_i = '0;
  logic              drain_i = 1'b0;
  logic              drain_done_o;
  logic              busy_o;
  logic [N*CW-1:0]   occupancy_o;
  logic              err_o;

  fifo_push_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .QUOTA      (QUOTA)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .fifo_push_o   (fifo_push_o),
    .fifo_data_o   (fifo_data_o),
    .fifo_full_i   (fifo_full_i),
    .fifo_pop_i    (fifo_pop_i),
    .fifo_pop_id_i (fifo_pop_id_i),
    .drain_i       (drain_i),
    .drain_done_o  (drain_done_o),
    .busy_o        (busy_o),
    .occupancy_o   (occupancy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0]      ready;
    logic              push;
    logic [IDW+DW-1:0] data;
    logic [N*CW-1:0]   occ;
    logic              busy;
    logic              done;
    logic              err;
    logic              regs;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drv_done = 1'b0;

  // Reference model: counts, pointer and mode (0 run, 1 drain, 2 done).
  int m_cnt[N];
  int m_rr    = 0;
  int m_mode  = 0;
  bit m_err   = 1'b0;
  bit m_known = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit rst, input bit flush, input bit drain, input bit full,
                      input bit pop, input int pop_id, input logic [N-1:0] valid);
    exp_t e;
    int   win;
    bit   zero;
    logic [IDW-1:0] wid;
    @(negedge clk_i);
    rst_i         = rst;
    flush_i       = flush;
    drain_i       = drain;
    fifo_full_i   = full;
    fifo_pop_i    = pop;
    fifo_pop_id_i = pop_id[IDW-1:0];
    req_valid_i   = valid;
    req_data_i    = {$urandom, $urandom, $urandom, $urandom};
    #1;
    win = -1;
    if (!rst && m_mode == 0 && !drain && !full && !flush) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (win < 0 && valid[idx] && m_cnt[idx] < QUOTA) win = idx;
      end
    end
    e.ready = '0;
    e.data  = '0;
    e.push  = (win >= 0);
    if (win >= 0) begin
      wid         = win[IDW-1:0];
      e.ready[win] = 1'b1;
      e.data      = {wid, req_data_i[win*DW +: DW]};
    end
    e.busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.occ[i*CW +: CW] = m_cnt[i][CW-1:0];
      if (m_cnt[i] != 0) e.busy = 1'b1;
    end
    e.done = (m_mode == 2);
    e.err  = m_err;
    e.regs = m_known;
    q.push_back(e);

    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_rr = 0; m_mode = 0; m_err = 1'b0; m_known = 1'b1;
    end else if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_rr = 0;
    end else begin
      if (pop) begin
        if (pop_id < N && m_cnt[pop_id] > 0) m_cnt[pop_id]--;
        else m_err = 1'b1;
      end
      if (win >= 0) begin
        m_cnt[win]++;
        m_rr = (win + 1) % N;
      end
      zero = 1'b1;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) zero = 1'b0;
      case (m_mode)
        0: if (drain) m_mode = 1;
        1: if (!drain) m_mode = 0; else if (zero) m_mode = 2;
        default: if (!drain) m_mode = 0;
      endcase
    end
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("req_ready", 64'(req_ready_o), 64'(e.ready));
        chk("fifo_push", 64'(fifo_push_o), 64'(e.push));
        chk("fifo_data", 64'(fifo_data_o), 64'(e.data));
        if (e.regs) begin
          chk("occupancy", 64'(occupancy_o), 64'(e.occ));
          chk("busy", 64'(busy_o), 64'(e.busy));
          chk("drain_done", 64'(drain_done_o), 64'(e.done));
          chk("err", 64'(err_o), 64'(e.err));
        end
      end
    end
  end

  initial begin : driver
    bit dr;
    // Reset with requests present: no grant allowed.
    step(1, 0, 0, 0, 0, 0, 4'hF);
    step(1, 0, 0, 0, 0, 0, 4'hF);
    // Round robin with all valid.
    repeat (8) step(0, 0, 0, 0, 0, 0, 4'hF);
    // Quota on requester 2, then one pop releases one more grant.
    step(1, 0, 0, 0, 0, 0, 4'h0);
    repeat (6) step(0, 0, 0, 0, 0, 0, 4'b0100);
    step(0, 0, 0, 0, 1, 2, 4'b0100);
    repeat (2) step(0, 0, 0, 0, 0, 0, 4'b0100);
    // Grant and pop to requester 1 together, then pop of an empty id.
    step(1, 0, 0, 0, 0, 0, 4'h0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 4'b0010);
    step(0, 0, 0, 0, 1, 1, 4'b0010);
    step(0, 0, 0, 0, 1, 3, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 4'b0000);
    // Drain with three outstanding entries.
    step(1, 0, 0, 0, 0, 0, 4'h0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 4'b0111);
    step(0, 0, 1, 0, 0, 0, 4'hF);
    step(0, 0, 1, 0, 1, 0, 4'hF);
    step(0, 0, 1, 0, 1, 1, 4'hF);
    step(0, 0, 1, 0, 1, 2, 4'hF);
    repeat (2) step(0, 0, 1, 0, 0, 0, 4'hF);
    repeat (2) step(0, 0, 0, 0, 0, 0, 4'hF);
    // Drain from an empty state, then reset while done.
    step(1, 0, 0, 0, 0, 0, 4'h0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 4'h0);
    step(1, 0, 1, 0, 0, 0, 4'hF);
    step(0, 0, 0, 0, 0, 0, 4'h0);
    // Full blocks grants and holds the pointer; release goes to the pointer index.
    step(0, 0, 0, 0, 0, 0, 4'b0001);
    repeat (3) step(0, 0, 0, 1, 0, 0, 4'hF);
    repeat (2) step(0, 0, 0, 0, 0, 0, 4'hF);
    // Flush with a pending request.
    step(0, 1, 0, 0, 1, 0, 4'hF);
    repeat (2) step(0, 0, 0, 0, 0, 0, 4'hF);
    // Random traffic.
    dr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) dr = ~dr;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, dr,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, N - 1)), 4'($urandom));
    end
    @(negedge clk_i);
    #3;
    drv_done = 1'b1;
  end

  initial begin : finisher
    wait (drv_done);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
